// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch unit.
//   Owns the PC (reset to RESET_PC) and issues one fetch at a time to
//   instruction memory over a valid/ready request channel. It accepts
//   redirects from execute, and buffers fetched {pc, inst} pairs in a small
//   FIFO that feeds decode through a valid/ready handshake.
//
// Optional build macro:
//   IFU_RSP_BYPASS_EN  when defined, a response that arrives while the FIFO
//                      is empty is presented to decode in the same cycle.
//                      When undefined, every response goes through the FIFO
//                      and nothing from imem_rsp_* reaches out_* combinationally.
//
// Ports:
//   clk, rst                          clock; synchronous active-high reset
//   imem_req_valid/ready/addr         fetch request channel (addr = fetch PC)
//   imem_rsp_valid/data               fetch response (always accepted)
//   redirect_valid/redirect_pc        redirect from execute (branch/jump/trap)
//   out_valid/ready/pc/inst           fetch-buffer head towards decode
//
// state  | meaning
// S_REQ  | idle or requesting; a request issues when the buffer has room
// S_WAIT | one request outstanding; its response will be kept
// S_DROP | one request outstanding; its response will be discarded
module ifu_fetch #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = XLEN'(32'h80000000),
   parameter int              FIFO_DEPTH = 2,
   parameter int              ILEN       = 32
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [ILEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [ILEN-1:0] out_inst
);

   localparam logic [1:0] S_REQ  = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DROP = 2'd2;

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   logic [1:0]      state;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] req_pc;
   logic [CNT_W-1:0] count;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];
   logic [ILEN-1:0] fifo_inst [FIFO_DEPTH];
   logic [XLEN-1:0] hold_pc;
   logic [ILEN-1:0] hold_inst;

   logic fifo_nonempty;
   logic req_fire;
   logic rsp_take;
   logic bypass;
   logic push;
   logic pop;

   assign fifo_nonempty = (count != '0);
   assign imem_req_addr = fetch_pc;

   // Outputs are gated by rst so nothing is offered while reset is held,
   // even before the first reset edge has cleared the registers.
   assign imem_req_valid = !rst && (state == S_REQ) && (count < DEPTH_C) && !redirect_valid;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response is kept only when it belongs to a live request and no
   // redirect squashes it in the same cycle.
   assign rsp_take = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;

`ifdef IFU_RSP_BYPASS_EN
   assign bypass = !rst && rsp_take && !fifo_nonempty;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed response taken by decode in the same cycle never enters the FIFO.
   assign push = rsp_take && !(bypass && out_ready);
   assign pop  = fifo_nonempty && out_ready;

   assign out_valid = !rst && (fifo_nonempty || bypass);

   always_comb begin
      out_pc   = hold_pc;
      out_inst = hold_inst;
      if (fifo_nonempty) begin
         out_pc   = fifo_pc[rd_ptr];
         out_inst = fifo_inst[rd_ptr];
      end else if (bypass) begin
         out_pc   = req_pc;
         out_inst = imem_rsp_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_REQ;
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
      end else begin
         if (redirect_valid) begin
            fetch_pc <= redirect_pc;
         end else if (req_fire) begin
            fetch_pc <= fetch_pc + XLEN'(4);
         end

         if (req_fire) begin
            req_pc <= fetch_pc;
         end

         case (state)
            S_REQ: begin
               if (req_fire) state <= S_WAIT;
            end
            S_WAIT: begin
               if (imem_rsp_valid)      state <= S_REQ;
               else if (redirect_valid) state <= S_DROP;
            end
            S_DROP: begin
               // The outstanding response is the one being discarded; once it
               // arrives nothing is in flight, whatever redirects happened.
               if (imem_rsp_valid) state <= S_REQ;
            end
            default: state <= S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count     <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         hold_pc   <= '0;
         hold_inst <= '0;
      end else begin
         // Remember what decode last saw so the head holds when empty.
         hold_pc   <= out_pc;
         hold_inst <= out_inst;
         if (redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !redirect_valid && push) begin
         fifo_pc[wr_ptr]   <= req_pc;
         fifo_inst[wr_ptr] <= imem_rsp_data;
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

   localparam int          D     = 2;
   localparam logic [31:0] RST_V = 32'h80000000;

   logic        clk = 1'b0;
   logic        rst, imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, out_pc, out_inst;
   logic        redirect_valid, out_valid, out_ready;

   always #5 clk = ~clk;

   ifu_fetch #(.XLEN(32), .RESET_PC(RST_V), .FIFO_DEPTH(D), .ILEN(32)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_inst(out_inst)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a queue of fetched pairs plus "one request in flight"
   // and "that request is squashed" flags.
   logic [63:0] m_q[$];
   logic [31:0] m_fetch = RST_V, m_req_pc = '0, m_hold_pc = '0, m_hold_inst = '0;
   bit          m_pend = 0, m_sq = 0;

   // Memory responder used during the random phase.
   bit          mem_busy = 0;
   int          mem_delay = 0;
   logic [31:0] mem_data = '0;

   typedef struct {
      logic rst, rdy, rsp; logic [31:0] data; logic redir; logic [31:0] rpc; logic ordy;
      logic e_rv; logic [31:0] e_addr; logic e_ov; logic [31:0] e_pc, e_inst;
   } vec_t;

   function automatic vec_t mk(logic r, logic rdy, logic rsp, logic [31:0] data, logic redir,
                               logic [31:0] rpc, logic ordy, logic e_rv, logic [31:0] e_addr,
                               logic e_ov, logic [31:0] e_pc, logic [31:0] e_inst);
      vec_t v;
      v.rst = r; v.rdy = rdy; v.rsp = rsp; v.data = data; v.redir = redir; v.rpc = rpc;
      v.ordy = ordy; v.e_rv = e_rv; v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc = e_pc;
      v.e_inst = e_inst;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic apply(input logic r, input logic rdy, input logic rsp, input logic [31:0] data,
                        input logic redir, input logic [31:0] rpc, input logic ordy);
      rst = r; imem_req_ready = rdy; imem_rsp_valid = rsp; imem_rsp_data = data;
      redirect_valid = redir; redirect_pc = rpc; out_ready = ordy;
      #1;
   endtask

   // Compare DUT against the model for the current inputs, clock once,
   // then advance the model and the memory responder.
   task automatic tick();
      logic        e_rv, e_ov, byp, fire, pop;
      logic [31:0] e_pc, e_inst;
      byp = 1'b0;
`ifdef IFU_RSP_BYPASS_EN
      byp = !rst && m_pend && !m_sq && imem_rsp_valid && !redirect_valid && (m_q.size() == 0);
`endif
      e_rv = !rst && !m_pend && (m_q.size() < D) && !redirect_valid;
      e_ov = !rst && ((m_q.size() != 0) || byp);
      if (m_q.size() != 0) begin
         e_pc = m_q[0][63:32]; e_inst = m_q[0][31:0];
      end else if (byp) begin
         e_pc = m_req_pc; e_inst = imem_rsp_data;
      end else begin
         e_pc = m_hold_pc; e_inst = m_hold_inst;
      end
      chk("m_req_valid", {31'd0, imem_req_valid}, {31'd0, e_rv});
      chk("m_out_valid", {31'd0, out_valid}, {31'd0, e_ov});
      if (!rst) begin
         chk("m_req_addr", imem_req_addr, m_fetch);
         chk("m_out_pc", out_pc, e_pc);
         chk("m_out_inst", out_inst, e_inst);
      end
      fire = imem_req_valid && imem_req_ready;
      pop  = e_ov && out_ready;
      @(posedge clk);
      if (rst) begin
         m_fetch = RST_V; m_q.delete(); m_pend = 0; m_sq = 0;
         m_hold_pc = '0; m_hold_inst = '0;
         mem_busy = 0;
      end else begin
         m_hold_pc = e_pc; m_hold_inst = e_inst;
         if (redirect_valid) begin
            m_fetch = redirect_pc;
            m_q.delete();
            if (m_pend) begin
               if (imem_rsp_valid) begin m_pend = 0; m_sq = 0; end
               else m_sq = 1;
            end
         end else begin
            if (pop && m_q.size() != 0) void'(m_q.pop_front());
            if (m_pend && imem_rsp_valid) begin
               if (!m_sq && !(byp && out_ready)) m_q.push_back({m_req_pc, imem_rsp_data});
               m_pend = 0; m_sq = 0;
            end
            if (e_rv && imem_req_ready) begin
               m_pend = 1; m_req_pc = m_fetch; m_fetch = m_fetch + 32'd4;
            end
         end
         if (imem_rsp_valid) mem_busy = 0;
         else if (mem_busy && mem_delay > 0) mem_delay--;
         if (fire) begin
            mem_busy = 1; mem_delay = $urandom_range(0, 3); mem_data = $urandom;
         end
      end
      #1;
   endtask

   vec_t tbl[11];

   initial begin
      //             rst rdy rsp data           rd rpc ordy | rv addr          ov pc            inst
      tbl[0]  = mk(1, 0, 0, 32'h0,        0, 0, 0,   0, 32'h0,        0, 32'h0,        32'h0);
      tbl[1]  = mk(0, 1, 0, 32'h0,        0, 0, 0,   1, 32'h80000000, 0, 32'h0,        32'h0);
      tbl[2]  = mk(0, 1, 1, 32'h13,       0, 0, 0,   0, 32'h80000004, 0, 32'h0,        32'h0);
      tbl[3]  = mk(0, 1, 0, 32'h0,        0, 0, 0,   1, 32'h80000004, 1, 32'h80000000, 32'h13);
      tbl[4]  = mk(0, 1, 1, 32'h13,       0, 0, 0,   0, 32'h80000008, 1, 32'h80000000, 32'h13);
      tbl[5]  = mk(0, 1, 0, 32'h0,        0, 0, 0,   0, 32'h80000008, 1, 32'h80000000, 32'h13);
      tbl[6]  = mk(0, 1, 0, 32'h0,        0, 0, 0,   0, 32'h80000008, 1, 32'h80000000, 32'h13);
      tbl[7]  = mk(0, 1, 0, 32'h0,        0, 0, 1,   0, 32'h80000008, 1, 32'h80000000, 32'h13);
      tbl[8]  = mk(0, 1, 0, 32'h0,        0, 0, 1,   1, 32'h80000008, 1, 32'h80000004, 32'h13);
      tbl[9]  = mk(0, 1, 1, 32'h00100093, 0, 0, 1,   0, 32'h8000000C, 0, 32'h80000004, 32'h13);
      tbl[10] = mk(0, 1, 0, 32'h0,        0, 0, 1,   1, 32'h8000000C, 1, 32'h80000008, 32'h00100093);

      #1;
      for (int i = 0; i < 11; i++) begin
         apply(tbl[i].rst, tbl[i].rdy, tbl[i].rsp, tbl[i].data, tbl[i].redir, tbl[i].rpc, tbl[i].ordy);
         chk($sformatf("tbl%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, tbl[i].e_rv});
         chk($sformatf("tbl%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
         if (!tbl[i].rst) begin
            chk($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_out_pc", i), out_pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d_out_inst", i), out_inst, tbl[i].e_inst);
         end
         tick();
      end

      // Redirect while waiting; the response three cycles later is discarded.
      apply(1, 0, 0, 0, 0, 0, 0); tick();
      apply(0, 1, 0, 0, 0, 0, 0); chk("drop_first_req", {31'd0, imem_req_valid}, 32'd1); tick();
      apply(0, 1, 0, 0, 1, 32'h80001000, 0); tick();
      apply(0, 1, 0, 0, 0, 0, 0);
      chk("drop_no_req", {31'd0, imem_req_valid}, 32'd0);
      chk("drop_addr", imem_req_addr, 32'h80001000);
      tick();
      apply(0, 1, 0, 0, 0, 0, 0); tick();
      apply(0, 1, 1, 32'hDEADBEEF, 0, 0, 0); tick();
      apply(0, 1, 0, 0, 0, 0, 0);
      chk("drop_discarded", {31'd0, out_valid}, 32'd0);
      chk("drop_resume_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("drop_resume_addr", imem_req_addr, 32'h80001000);
      tick();

      // Redirect in the same cycle as the response.
      apply(0, 1, 1, 32'h12345678, 1, 32'h80002000, 0); tick();
      apply(0, 0, 0, 0, 0, 0, 0);
      chk("samecyc_no_push", {31'd0, out_valid}, 32'd0);
      chk("samecyc_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("samecyc_addr", imem_req_addr, 32'h80002000);
      tick();

      // PC wrap at the top of the address space.
      apply(0, 1, 0, 0, 1, 32'hFFFFFFFC, 0);
      chk("redir_blocks_req", {31'd0, imem_req_valid}, 32'd0);
      tick();
      apply(0, 1, 0, 0, 0, 0, 0); chk("wrap_req_addr", imem_req_addr, 32'hFFFFFFFC); tick();
      apply(0, 1, 1, 32'h00000033, 0, 0, 0); chk("wrap_next_addr", imem_req_addr, 32'h0); tick();
      apply(0, 1, 0, 0, 0, 0, 0);
      chk("wrap_out_valid", {31'd0, out_valid}, 32'd1);
      chk("wrap_out_pc", out_pc, 32'hFFFFFFFC);
      chk("wrap_out_inst", out_inst, 32'h33);
      tick();

      // Reset while waiting with one entry buffered.
      apply(1, 1, 0, 0, 0, 0, 0);
      chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      tick();
      apply(1, 1, 0, 0, 0, 0, 0);
      chk("rst_hold_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("rst_hold_out_valid", {31'd0, out_valid}, 32'd0);
      tick();
      apply(0, 1, 0, 0, 0, 0, 0);
      chk("rst_rel_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("rst_rel_addr", imem_req_addr, RST_V);
      chk("rst_rel_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_rel_out_pc", out_pc, 32'h0);
      chk("rst_rel_out_inst", out_inst, 32'h0);
      tick();

      // Random traffic against the model.
      apply(1, 0, 0, 0, 0, 0, 0); tick();
      for (int c = 0; c < 4000; c++) begin
         logic        r, rdy, rsp, redir, ordy;
         logic [31:0] rpc;
         int          stall;
         stall = ((c / 500) % 2 == 1) ? 4 : 1;
         r     = ($urandom_range(0, 249) == 0);
         rdy   = ($urandom_range(0, 3) != 0);
         rsp   = mem_busy && (mem_delay == 0);
         redir = ($urandom_range(0, 15) == 0);
         rpc   = $urandom;
         if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
         if ($urandom_range(0, 31) == 0) rpc = 32'hFFFFFFFC;
         ordy  = ($urandom_range(0, stall) == 0);
         apply(r, rdy, rsp, rsp ? mem_data : $urandom, redir, rpc, ordy);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
